// File: rtl/telemetry_rx.sv
// telemetry_rx: 8N1 UART receiver and packet reassembler for the eBike
// telemetry stream (AA 55 header, then 12-bit batt/curr/torque).
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  typedef enum logic {
    B_IDLE,
    B_RCV
  } bit_st_t;

  typedef enum logic [1:0] {
    P_HDR1,
    P_HDR2,
    P_DATA
  } pkt_st_t;

  logic          r_rx_s1;
  logic          r_rx_s2;
  bit_st_t       r_bst;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bits;
  logic [7:0]    r_shift;
  logic          r_frm_err;

  pkt_st_t       r_pst;
  logic [2:0]    r_idx;
  logic [3:0]    r_b_hi;
  logic [7:0]    r_b_lo;
  logic [3:0]    r_c_hi;
  logic [7:0]    r_c_lo;
  logic [3:0]    r_t_hi;
  logic [11:0]   r_batt;
  logic [11:0]   r_curr;
  logic [11:0]   r_torque;
  logic          r_vld;

  logic [CW-1:0] w_cnt_nxt;
  logic          w_tick;
  logic          w_stop;
  logic          w_byte_ok;
  logic          w_byte_bad;

  assign w_cnt_nxt  = r_cnt - CW'(1);
  assign w_tick     = (r_bst == B_RCV) && (w_cnt_nxt == '0);
  assign w_stop     = w_tick && (r_bits == 4'd9);
  assign w_byte_ok  = w_stop && r_rx_s2;
  assign w_byte_bad = w_stop && !r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bst     <= B_IDLE;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_shift   <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_frm_err <= 1'b0;
      unique case (r_bst)
        B_IDLE: begin
          if (!r_rx_s2) begin
            r_bst  <= B_RCV;
            r_cnt  <= HALF;
            r_bits <= '0;
          end
        end
        B_RCV: begin
          if (!w_tick) begin
            r_cnt <= w_cnt_nxt;
          end else begin
            r_cnt  <= FULL;
            r_bits <= r_bits + 4'd1;
            unique case (1'b1)
              (r_bits == 4'd0): begin
                if (r_rx_s2)
                  r_bst <= B_IDLE;
              end
              (r_bits == 4'd9): begin
                r_bst     <= B_IDLE;
                r_frm_err <= !r_rx_s2;
              end
              default: begin
                r_shift <= {r_rx_s2, r_shift[7:1]};
              end
            endcase
          end
        end
      endcase
    end
  end

  // Bytes are consumed on the stop-sample edge, so vld lands one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pst    <= P_HDR1;
      r_idx    <= '0;
      r_b_hi   <= '0;
      r_b_lo   <= '0;
      r_c_hi   <= '0;
      r_c_lo   <= '0;
      r_t_hi   <= '0;
      r_batt   <= '0;
      r_curr   <= '0;
      r_torque <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_byte_bad) begin
        r_pst <= P_HDR1;
        r_idx <= '0;
      end else if (w_byte_ok) begin
        unique case (r_pst)
          P_HDR1: begin
            if (r_shift == 8'hAA)
              r_pst <= P_HDR2;
          end
          P_HDR2: begin
            unique case (1'b1)
              (r_shift == 8'h55): begin
                r_pst <= P_DATA;
                r_idx <= '0;
              end
              (r_shift == 8'hAA): r_pst <= P_HDR2;
              default:            r_pst <= P_HDR1;
            endcase
          end
          P_DATA: begin
            r_idx <= r_idx + 3'd1;
            unique case (r_idx)
              3'd0: r_b_hi <= r_shift[3:0];
              3'd1: r_b_lo <= r_shift;
              3'd2: r_c_hi <= r_shift[3:0];
              3'd3: r_c_lo <= r_shift;
              3'd4: r_t_hi <= r_shift[3:0];
              default: begin
                r_batt   <= {r_b_hi, r_b_lo};
                r_curr   <= {r_c_hi, r_c_lo};
                r_torque <= {r_t_hi, r_shift};
                r_vld    <= 1'b1;
                r_pst    <= P_HDR1;
                r_idx    <= '0;
              end
            endcase
          end
          default: r_pst <= P_HDR1;
        endcase
      end
    end
  end

  assign batt    = r_batt;
  assign curr    = r_curr;
  assign torque  = r_torque;
  assign vld     = r_vld;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_telemetry_rx.sv
// tb_telemetry_rx: directed and random byte streams against a
// packet-level reference model of the telemetry receiver.
module tb_telemetry_rx;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] batt;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        vld;
  logic        frm_err;

  telemetry_rx #(.BAUD_DIV(BD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .batt   (batt),
    .curr   (curr),
    .torque (torque),
    .vld    (vld),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  longint      cyc = 0;
  logic [7:0]  s_byte[$];
  bit          s_bad[$];
  logic [35:0] obs_q[$];
  longint      vld_t[$];
  int          ferr_seen = 0;
  int          obs_base = 0;
  int          ferr_base = 0;
  logic [35:0] exp_q[$];
  int          exp_ferr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld) begin
      obs_q.push_back({batt, curr, torque});
      vld_t.push_back(cyc);
    end
    if (frm_err) ferr_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                           input int gap);
    logic [9:0] fr;
    int         g;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (BD) @(posedge clk);
    end
    RX = 1'b1;
    g = stop_ok ? gap : gap + 12;
    repeat (g * BD) @(posedge clk);
    s_byte.push_back(b);
    s_bad.push_back(!stop_ok);
  endtask

  task automatic send_pkt(input logic [7:0] pk[8], input int gap);
    for (int i = 0; i < 8; i++) send_byte(pk[i], 1'b1, gap);
  endtask

  // Scan the byte stream: a header is AA immediately followed by 55,
  // the next six bytes are data; any bad byte restarts the scan after it.
  function automatic void run_model();
    int         p;
    int         n;
    int         q;
    logic [7:0] d[6];
    p = 0;
    n = s_byte.size();
    exp_q.delete();
    exp_ferr = 0;
    while (p < n) begin
      if (s_bad[p]) begin
        exp_ferr++;
        p++;
      end else if (p + 1 < n && s_byte[p] == 8'hAA &&
                   s_byte[p+1] == 8'h55 && !s_bad[p+1]) begin
        q = -1;
        for (int k = p + 2; k < p + 8 && k < n; k++)
          if (q < 0 && s_bad[k]) q = k;
        if (q >= 0) begin
          p = q;
        end else if (p + 8 <= n) begin
          for (int k = 0; k < 6; k++) d[k] = s_byte[p+2+k];
          exp_q.push_back({d[0][3:0], d[1], d[2][3:0], d[3],
                           d[4][3:0], d[5]});
          p += 8;
        end else begin
          p = n;
        end
      end else begin
        p++;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [35:0] last;
    repeat (30) @(posedge clk);
    @(negedge clk);
    run_model();
    chk({tag, "_nvld"}, obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_base + i < obs_q.size())
        chk({tag, "_pkt"}, obs_q[obs_base+i], exp_q[i]);
    chk({tag, "_nferr"}, ferr_seen - ferr_base, exp_ferr);
    last = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : 36'h0;
    chk({tag, "_out"}, {batt, curr, torque}, last);
  endtask

  logic [7:0] pk[8];
  int         b2b;
  int         bi;

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {batt, curr, torque}, 36'h0);
    chk("rst_vld", vld, 1'b0);
    chk("rst_ferr", frm_err, 1'b0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    pk = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    send_pkt(pk, 1);
    compare_all("clean");
    chk("clean_val", {batt, curr, torque}, 36'hABC123FFF);

    send_byte(8'h12, 1'b1, 0);
    send_byte(8'hAA, 1'b1, 0);
    pk = '{8'hAA, 8'h55, 8'h03, 8'h00, 8'h00, 8'h40, 8'h08, 8'h00};
    send_pkt(pk, 0);
    compare_all("garbage");
    chk("garbage_val", {batt, curr, torque}, 36'h300040800);

    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b0, 0);
    compare_all("ferr");
    chk("ferr_hold", {batt, curr, torque}, 36'h300040800);
    pk = '{8'hAA, 8'h55, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
    send_pkt(pk, 0);
    compare_all("after_ferr");
    chk("after_ferr_val", {batt, curr, torque}, 36'h011022033);

    RX = 1'b0;
    repeat (4) @(posedge clk);
    RX = 1'b1;
    repeat (40) @(posedge clk);
    compare_all("glitch");
    pk = '{8'hAA, 8'h55, 8'hF7, 8'h5A, 8'h02, 8'hC3, 8'h09, 8'h18};
    send_pkt(pk, 1);
    compare_all("post_glitch");
    chk("post_glitch_val", {batt, curr, torque}, 36'h75A2C3918);

    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    RX = 1'b0;
    repeat (3 * BD) @(posedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    obs_base = obs_q.size();
    ferr_base = ferr_seen;
    s_byte.delete();
    s_bad.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_out", {batt, curr, torque}, 36'h0);
    chk("midrst_vld", vld, 1'b0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    compare_all("midrst_idle");
    pk = '{8'hAA, 8'h55, 8'h04, 8'h56, 8'h07, 8'h89, 8'h01, 8'h23};
    send_pkt(pk, 1);
    compare_all("midrst_pkt");

    b2b = vld_t.size();
    pk = '{8'hAA, 8'h55, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33};
    send_pkt(pk, 0);
    pk = '{8'hAA, 8'h55, 8'h0E, 8'hEE, 8'h0D, 8'hDD, 8'h0C, 8'hCC};
    send_pkt(pk, 0);
    compare_all("b2b");
    chk("b2b_npulse", vld_t.size() - b2b, 2);
    if (vld_t.size() - b2b >= 2)
      chk("b2b_spacing", vld_t[b2b+1] - vld_t[b2b], 80 * BD);

    for (int it = 0; it < 8; it++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--)
        send_byte(8'($urandom), 1'b1, $urandom_range(0, 2));
      pk[0] = 8'hAA;
      pk[1] = 8'h55;
      for (int i = 2; i < 8; i++) pk[i] = 8'($urandom);
      bi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      for (int i = 0; i < 8; i++)
        send_byte(pk[i], i != bi, $urandom_range(0, 1));
      compare_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/telemetry_rx.md
# telemetry_rx

Receive-side counterpart to the eBike's `TX` telemetry output. It deserializes 8N1 UART frames from the `TX` line, locates the two-byte packet header, and reassembles the 12-bit battery, current and torque readings. It then presents them as registered words with a one-cycle valid pulse. It is used in the bench and on a companion board to check the eBike's transmitted telemetry.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud); must be ≥ 8.
- `clk`  in  1  50 MHz system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `RX`  in  1  serial input, idle high; connect to eBike `TX`
- `batt`  out  12  last received battery reading
- `curr`  out  12  last received current reading
- `torque`  out  12  last received torque reading
- `vld`  out  1  one-cycle pulse: `batt`/`curr`/`torque` just updated
- `frm_err`  out  1  one-cycle pulse: framing error (stop bit sampled low)

## Operation
- **Input synchronizer:** `RX` passes through a 2-flop synchronizer. Both flops preset to 1 on reset.
- **Bit FSM:**
  - States: IDLE, RCV.
  - **IDLE:** a synchronized `RX` of 0 enters RCV. On entry, the baud counter loads `BAUD_DIV/2` (integer divide) and the bit count clears.
  - **RCV, sampling:** the baud counter decrements every clock. At 0 it samples `RX`, shifts the sample in LSB-first, reloads `BAUD_DIV`, and increments the bit count.
  - **Start bit:** the first sample is the start bit. If it reads 1 (glitch), return to IDLE silently with no error.
  - **Byte done:** the 10th sample (stop bit) ends the byte and returns the FSM to IDLE. Stop = 1 gives a good byte; stop = 0 pulses `frm_err` and discards the byte.
- **Packet format** (8 bytes, fixed): 0xAA, 0x55, batt[11:8], batt[7:0], curr[11:8], curr[7:0], torque[11:8], torque[7:0]. Upper nibble of high bytes ignored (only [3:0] used).
- **Packet FSM** (advances only on good bytes):
  - States: HDR1, HDR2, DATA.
  - **HDR1:** 0xAA → HDR2; any other byte stays in HDR1.
  - **HDR2:** 0x55 → DATA with the byte index cleared; 0xAA stays in HDR2; any other byte → HDR1.
  - **DATA:** each byte goes into a 6-byte staging buffer at the current index, then the index increments. The 6th byte triggers an update of all three outputs at once from the staging buffer, pulses `vld`, and returns to HDR1.
- **Framing error:** forces the packet FSM to HDR1 and discards any partially staged data. The outputs keep their previous values.
- **Output hold:** outputs are never partially updated; they hold between packets.
- **Reset:** all outputs, staging buffer and counters go to 0. Both FSMs go to IDLE/HDR1. Reset asserted mid-byte or mid-packet abandons it with no `vld` and no `frm_err`.

## Timing
- **Synchronizer latency:** `RX` to FSM, 2 clocks.
- **Sample points:** for a start edge seen by the FSM at cycle t:
  - start-bit sample at t + `BAUD_DIV/2`;
  - data bit k (0..7) at t + `BAUD_DIV/2` + (k+1)·`BAUD_DIV`;
  - stop bit at t + `BAUD_DIV/2` + 9·`BAUD_DIV`.
- **Output update:** `vld` and the output update occur in the clock after the stop-bit sample of the 8th packet byte. `vld` is high for exactly 1 clock.
- **`frm_err` timing:** asserted in the clock after a low stop-bit sample, for 1 clock.
- **Back-to-back bytes:** a new start bit can be detected in the cycle after the stop sample. This tolerates zero idle time between bytes and a ±2% baud mismatch.

## Test plan
Use `BAUD_DIV` = 16 throughout.
- **Clean packet:** drive AA 55 0A BC 01 23 0F FF → exactly one `vld` pulse, `batt`=0xABC, `curr`=0x123, `torque`=0xFFF, `frm_err` never asserted.
- **Leading garbage:** drive 12 AA AA 55 03 00 00 40 08 00 → one `vld` pulse, `batt`=0x300, `curr`=0x040, `torque`=0x800.
- **Framing error:** drive AA 55 01 02 with the stop bit of the 4th byte forced low → `frm_err` one-cycle pulse, no `vld`, outputs unchanged. A following clean packet AA 55 00 11 00 22 00 33 → `vld`, `batt`=0x011, `curr`=0x022, `torque`=0x033.
- **Start glitch:** pull `RX` low for 4 clocks then high → no state change and no pulses. The next clean packet decodes correctly.
- **Reset mid-packet:** assert `rst_n` low during the 5th byte → all outputs 0, no `vld`. After release, a full packet decodes normally.
- **Back-to-back packets:** send two packets with zero idle bits between them → two `vld` pulses, 80·16 clocks apart. Outputs match each packet in turn.
